// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: serial-adder FSM states, adder slice width
// and a helper giving the number of slices per operand.
package arith_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} ser_state_t;

    localparam int NIB = 4;

    function automatic int nibbles(input int w);
        return w / NIB;
    endfunction

endpackage

// File: rtl/nibble_adder4.sv
// Combinational 4-bit ripple-carry adder assembled from 1-bit full-adder cells.
module full_adder1 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

module nibble_adder4
    import arith_pkg::*;
(
    input  logic [NIB-1:0] a,
    input  logic [NIB-1:0] b,
    input  logic           cin,
    output logic [NIB-1:0] sum,
    output logic           cout
);

    logic [NIB:0] carryChain;

    assign carryChain[0] = cin;

    for (genvar i = 0; i < NIB; i++) begin : gCell
        full_adder1 uFa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carryChain[i]),
            .sum  (sum[i]),
            .cout (carryChain[i+1])
        );
    end

    assign cout = carryChain[NIB];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Serial WIDTH-bit adder: one shared 4-bit adder consumes a nibble per cycle,
// LSB first, with the carry held in a flop between slices.
module nibble_serial_add_ctrl
    import arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_a,
    input  logic [WIDTH-1:0] io_in_b,
    input  logic             io_in_carryIn,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_sum,
    output logic             io_out_carryOut,
    output logic             io_busy
);

    localparam int NIBS  = nibbles(WIDTH);
    localparam int CNT_W = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBS - 1);

    ser_state_t state, nextState;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] aQ;
    logic [WIDTH-1:0] bQ;
    logic [WIDTH-1:0] sumQ;
    logic             carryQ;

    logic [NIB-1:0]   sliceSum;
    logic             sliceCout;

    logic             inReadyDec;
    logic             outValidDec;
    logic             busyDec;

    nibble_adder4 uAdder (
        .a    (aQ[NIB-1:0]),
        .b    (bQ[NIB-1:0]),
        .cin  (carryQ),
        .sum  (sliceSum),
        .cout (sliceCout)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState   = state;
        inReadyDec  = 1'b0;
        outValidDec = 1'b0;
        busyDec     = 1'b0;
        case (state)
            IDLE: begin
                inReadyDec = 1'b1;
                if (io_in_valid) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                busyDec = 1'b1;
                if (cnt == LAST_CNT) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                busyDec     = 1'b1;
                outValidDec = 1'b1;
                if (io_out_ready) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Each RUN cycle retires the low nibble and shifts the next one into the adder.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt    <= '0;
            aQ     <= '0;
            bQ     <= '0;
            sumQ   <= '0;
            carryQ <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (io_in_valid) begin
                        aQ     <= io_in_a;
                        bQ     <= io_in_b;
                        carryQ <= io_in_carryIn;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    aQ     <= {{NIB{1'b0}}, aQ[WIDTH-1:NIB]};
                    bQ     <= {{NIB{1'b0}}, bQ[WIDTH-1:NIB]};
                    sumQ   <= {sliceSum, sumQ[WIDTH-1:NIB]};
                    carryQ <= sliceCout;
                    if (cnt != LAST_CNT) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs come from state and registers only; reset low forces them quiet.
    assign io_in_ready     = reset & inReadyDec;
    assign io_out_valid    = reset & outValidDec;
    assign io_busy         = reset & busyDec;
    assign io_out_sum      = io_out_valid ? sumQ : '0;
    assign io_out_carryOut = io_out_valid & carryQ;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for the nibble-serial adder at WIDTH=16: stimulus queues
// expected results, a monitor pops and compares on each output handshake.
module tb_nibble_serial_add_ctrl;

    localparam int WIDTH = 16;

    logic             clock;
    logic             reset;
    logic             io_in_valid;
    logic             io_in_ready;
    logic [WIDTH-1:0] io_in_a;
    logic [WIDTH-1:0] io_in_b;
    logic             io_in_carryIn;
    logic             io_out_valid;
    logic             io_out_ready;
    logic [WIDTH-1:0] io_out_sum;
    logic             io_out_carryOut;
    logic             io_busy;

    int checks = 0;
    int errors = 0;
    bit randReady = 1'b0;
    logic [WIDTH:0] expQ[$];

    nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .io_in_valid     (io_in_valid),
        .io_in_ready     (io_in_ready),
        .io_in_a         (io_in_a),
        .io_in_b         (io_in_b),
        .io_in_carryIn   (io_in_carryIn),
        .io_out_valid    (io_out_valid),
        .io_out_ready    (io_out_ready),
        .io_out_sum      (io_out_sum),
        .io_out_carryOut (io_out_carryOut),
        .io_busy         (io_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every accepted result must match the head of the scoreboard.
    always @(negedge clock) begin
        if (reset && io_out_valid && io_out_ready) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got %h/%b with nothing expected", io_out_sum, io_out_carryOut);
            end else begin
                logic [WIDTH:0] e;
                e = expQ.pop_front();
                if ({io_out_carryOut, io_out_sum} !== e) begin
                    errors++;
                    $display("FAIL result: got cout=%b sum=%h expected cout=%b sum=%h",
                             io_out_carryOut, io_out_sum, e[WIDTH], e[WIDTH-1:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        if (randReady) io_out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                        input logic [WIDTH-1:0] expSum, input logic expCout, input bit doPush);
        int n;
        io_in_a       = a;
        io_in_b       = b;
        io_in_carryIn = cin;
        io_in_valid   = 1'b1;
        n = 0;
        while (!io_in_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            errors++;
            checks++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        if (doPush) expQ.push_back({expCout, expSum});
        tick();
        io_in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain_remaining", 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rc;
        logic [WIDTH:0]   model;
        logic [WIDTH-1:0] heldSum;
        int n;

        reset         = 1'b0;
        io_in_valid   = 1'b0;
        io_in_a       = '0;
        io_in_b       = '0;
        io_in_carryIn = 1'b0;
        io_out_ready  = 1'b1;
        repeat (3) tick();
        check("reset_in_ready", 32'(io_in_ready), 32'd0);
        check("reset_out_valid", 32'(io_out_valid), 32'd0);
        check("reset_busy", 32'(io_busy), 32'd0);
        check("reset_sum", 32'(io_out_sum), 32'd0);
        check("reset_cout", 32'(io_out_carryOut), 32'd0);
        reset = 1'b1;
        tick();
        check("idle_in_ready", 32'(io_in_ready), 32'd1);

        // Carry across a nibble boundary, with latency measured from acceptance.
        send(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b1);
        repeat (3) tick();
        check("latency_not_yet", 32'(io_out_valid), 32'd0);
        check("run_in_ready", 32'(io_in_ready), 32'd0);
        check("run_busy", 32'(io_busy), 32'd1);
        tick();
        check("latency_valid", 32'(io_out_valid), 32'd1);
        drain();
        check("idle_sum_zero", 32'(io_out_sum), 32'd0);

        send(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1);
        drain();
        send(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        drain();
        send(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b1);
        drain();

        // Backpressure: result held while a competing request is offered.
        io_out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b1);
        n = 0;
        while (!io_out_valid && n < 50) begin
            tick();
            n++;
        end
        check("bp_valid_seen", 32'(io_out_valid), 32'd1);
        heldSum       = io_out_sum;
        io_in_a       = 16'hDEAD;
        io_in_b       = 16'hBEEF;
        io_in_valid   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_valid_hold", 32'(io_out_valid), 32'd1);
            check("bp_sum_hold", 32'(io_out_sum), 32'(heldSum));
            check("bp_sum_value", 32'(io_out_sum), 32'h3333);
            check("bp_in_ready", 32'(io_in_ready), 32'd0);
        end
        io_in_valid  = 1'b0;
        io_out_ready = 1'b1;
        drain();
        repeat (3) tick();
        check("bp_no_capture_busy", 32'(io_busy), 32'd0);

        // Reset at cnt=2 of RUN drops the pending operation.
        send(16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("midreset_busy_low", 32'(io_busy), 32'd0);
        check("midreset_ready_low", 32'(io_in_ready), 32'd0);
        tick();
        reset = 1'b1;
        #1;
        check("after_reset_ready", 32'(io_in_ready), 32'd1);
        check("after_reset_busy", 32'(io_busy), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("after_reset_no_valid", 32'(io_out_valid), 32'd0);
        end
        send(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b1);
        drain();

        // Back-to-back random traffic with random downstream readiness.
        randReady = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra    = 16'($urandom);
            rb    = 16'($urandom);
            rc    = 1'($urandom_range(0, 1));
            model = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
            send(ra, rb, rc, model[WIDTH-1:0], model[WIDTH], 1'b1);
        end
        randReady    = 1'b0;
        io_out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
